imm_buffer: RTL and testbench
=============================

IMM_BUFFER -- requirements
Module: imm_buffer

Interface
REQ-001 SHALL have parameter SIZE, default 16, number of immediate entries; power of two.
REQ-002 SHALL have parameter ENQ_NUM, default 4, allocate ports; equals RENAME_WIDTH.
REQ-003 SHALL have parameter READPORT_NUM, default 8, read ports; equals IMMBUFFER_READPORT_NUM.
REQ-004 SHALL have parameter CLEARPORT_NUM, default 8, clear ports; equals IMMBUFFER_CLEARPORT_NUM.
REQ-005 SHALL have parameter IMM_W, default 20, immediate width; matches imm_t.
REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port i_squash_vld, input, 1, backend flush.
REQ-009 SHALL have port o_can_enq, output, 1, at least ENQ_NUM entries are free.
REQ-010 SHALL have port i_enq_vld, input, ENQ_NUM, allocate requests.
REQ-011 SHALL have port i_enq_imm, input, ENQ_NUM x IMM_W, immediates to store.
REQ-012 SHALL have port o_enq_idx, output, ENQ_NUM x log2(SIZE), allocated index (irobIdx_t) per port.
REQ-013 SHALL have port i_read_idx, input, READPORT_NUM x log2(SIZE), read addresses from exeBlock.
REQ-014 SHALL have port o_read_data, output, READPORT_NUM x IMM_W, read data.
REQ-015 SHALL have port i_clear_vld, input, CLEARPORT_NUM, release requests.
REQ-016 SHALL have port i_clear_idx, input, CLEARPORT_NUM x log2(SIZE), entries to release.

Function
REQ-017 SHALL hold state: data[SIZE], busy[SIZE], head and tail pointers (log2(SIZE)+1 bits, MSB = wrap flag), count = tail - head.
REQ-018 SHALL drive o_can_enq = (SIZE - count) >= ENQ_NUM from registered state, independent of i_enq_vld.
REQ-019 SHALL require i_enq_vld to be a contiguous low-order prefix; any other pattern is a protocol error and its behaviour is undefined.
REQ-020 SHALL drive o_enq_idx[k] = (tail + k) mod SIZE combinationally for every k, whether or not port k is valid.
REQ-021 SHALL, when o_can_enq and not i_squash_vld, write data[tail+k] <= i_enq_imm[k] and busy <= 1 for each valid k, then advance tail by popcount(i_enq_vld).
REQ-022 SHALL ignore all enqueue requests in a cycle where o_can_enq = 0; tail and entries are unchanged.
REQ-023 SHALL drive o_read_data[p] = data[i_read_idx[p]] combinationally, with zero-cycle read latency.
REQ-024 SHALL make an enqueued immediate readable in the cycle after the enqueue.
REQ-025 SHALL NOT check busy on reads; a read of a non-busy entry returns its last written data.
REQ-026 SHALL, for each valid clear port, set busy[i_clear_idx] <= 0 at the next edge.
REQ-027 SHALL treat duplicate clear indices in one cycle as a single clear.
REQ-028 SHALL treat a clear of a non-busy entry as a no-op.
REQ-029 SHALL advance head each cycle by n, where n is the number of consecutive entries starting at head with registered busy = 0, limited to n <= ENQ_NUM and n <= count. Out-of-order clears free slots only when head reaches them.
REQ-030 SHALL give an entry cleared in cycle t its first chance to be reclaimed by head in cycle t+1.
REQ-031 SHALL compute the enqueue and the head advance in the same cycle from the same registered state; their combined effect on count is exact.
REQ-032 SHALL, on i_squash_vld, set head <= tail and clear every busy bit at the next edge. Same-cycle enqueues and clears are discarded, and o_can_enq = 1 in the following cycle.
REQ-033 SHALL handle pointer wrap by the wrap-flag MSB: count = SIZE when head and tail indices are equal and the flags differ, and count = 0 when both are equal.

Reset
REQ-034 SHALL, on rst asserted, asynchronously set head = tail = 0 and busy = 0; data is not reset.
REQ-035 SHALL drive o_can_enq = 1 and o_enq_idx[k] = k while reset is asserted and after deassertion.
REQ-036 SHALL, on reset asserted mid-operation, abandon all pending enqueues and clears with no partial update.

Verification
REQ-037 SHALL verify allocate and read: after reset, enq_vld=4'b0111 with imms 0x11,0x22,0x33 -> o_enq_idx=0,1,2; next cycle reads of idx 0,1,2 = 0x11,0x22,0x33; tail=3.
REQ-038 SHALL verify full: 4 enqueue cycles of 4'b1111 -> count=16, o_can_enq=0; a fifth enqueue is ignored and tail wrap flag=1.
REQ-039 SHALL verify out-of-order release: with entries 0-7 busy, clear idx 2 and 3 -> head stays 0; clear idx 0,1 -> head reaches 4 two cycles later.
REQ-040 SHALL verify wrap-around: with head=14, tail=14 (wrap 1), enqueue 4 -> o_enq_idx=14,15,0,1; reads of idx 0 and 1 return the new data.
REQ-041 SHALL verify squash: with 10 busy entries, squash together with enq 4'b1111 -> next cycle count=0, no entry busy, o_can_enq=1.
REQ-042 SHALL verify async reset: rst asserted between clock edges mid-stream -> head=tail=0 and o_can_enq=1 before the next clk edge.

Source files
------------

// File: rtl/imm_buffer.sv
// imm_buffer: circular immediate store with in-order allocation, combinational reads,
// out-of-order release and head reclamation limited to ENQ_NUM entries per cycle.
module imm_buffer #(
    parameter int SIZE          = 16,
    parameter int ENQ_NUM       = 4,
    parameter int READPORT_NUM  = 8,
    parameter int CLEARPORT_NUM = 8,
    parameter int IMM_W         = 20
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_squash_vld,
    output logic                                   o_can_enq,
    input  logic [ENQ_NUM-1:0]                     i_enq_vld,
    input  logic [ENQ_NUM*IMM_W-1:0]               i_enq_imm,
    output logic [ENQ_NUM*$clog2(SIZE)-1:0]        o_enq_idx,
    input  logic [READPORT_NUM*$clog2(SIZE)-1:0]   i_read_idx,
    output logic [READPORT_NUM*IMM_W-1:0]          o_read_data,
    input  logic [CLEARPORT_NUM-1:0]               i_clear_vld,
    input  logic [CLEARPORT_NUM*$clog2(SIZE)-1:0]  i_clear_idx
);
    localparam int AW = $clog2(SIZE);

    logic [IMM_W-1:0] r_data [SIZE];
    logic [SIZE-1:0]  r_busy;
    logic [AW:0]      r_head;
    logic [AW:0]      r_tail;
    logic [AW:0]      w_count;
    logic [AW:0]      w_enq_cnt;
    logic [AW:0]      w_adv;
    logic             w_stop;
    logic             w_enq_go;
    logic [SIZE-1:0]  w_busy_nxt;

    assign w_count   = r_tail - r_head;
    assign o_can_enq = ({1'b0, w_count} + (AW+2)'(ENQ_NUM)) <= (AW+2)'(SIZE);
    assign w_enq_go  = o_can_enq && !i_squash_vld;

    for (genvar g = 0; g < ENQ_NUM; g++) begin : g_idx
        assign o_enq_idx[g*AW +: AW] = r_tail[AW-1:0] + AW'(g);
    end

    for (genvar p = 0; p < READPORT_NUM; p++) begin : g_rd
        assign o_read_data[p*IMM_W +: IMM_W] = r_data[i_read_idx[p*AW +: AW]];
    end

    always_comb begin
        w_enq_cnt = '0;
        for (int k = 0; k < ENQ_NUM; k++)
            if (i_enq_vld[k]) w_enq_cnt = w_enq_cnt + (AW+1)'(1);
    end

    // head only reclaims a run of free entries, so out-of-order clears wait for it
    always_comb begin
        w_adv  = '0;
        w_stop = 1'b0;
        for (int k = 0; k < ENQ_NUM; k++) begin
            if (!w_stop && ((AW+1)'(k) < w_count) && !r_busy[r_head[AW-1:0] + AW'(k)])
                w_adv = w_adv + (AW+1)'(1);
            else
                w_stop = 1'b1;
        end
    end

    always_comb begin
        w_busy_nxt = r_busy;
        for (int c = 0; c < CLEARPORT_NUM; c++)
            if (i_clear_vld[c]) w_busy_nxt[i_clear_idx[c*AW +: AW]] = 1'b0;
        if (w_enq_go)
            for (int k = 0; k < ENQ_NUM; k++)
                if (i_enq_vld[k]) w_busy_nxt[r_tail[AW-1:0] + AW'(k)] = 1'b1;
        if (i_squash_vld) w_busy_nxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_head <= i_squash_vld ? r_tail : r_head + w_adv;
            r_tail <= w_enq_go ? r_tail + w_enq_cnt : r_tail;
        end
    end

    // payload is not reset; writes are still suppressed while reset is held
    always_ff @(posedge clk) begin
        if (!rst && w_enq_go)
            for (int k = 0; k < ENQ_NUM; k++)
                if (i_enq_vld[k]) r_data[r_tail[AW-1:0] + AW'(k)] <= i_enq_imm[k*IMM_W +: IMM_W];
    end
endmodule

// File: tb/tb_imm_buffer.sv
// tb_imm_buffer: scenario tasks for imm_buffer; enqueued immediates go to a scoreboard
// queue and are popped and compared through the read ports.
module tb_imm_buffer;
    localparam int SIZE = 16, EN = 4, RP = 8, CP = 8, IW = 20, AW = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             i_squash_vld = 1'b0;
    logic             o_can_enq;
    logic [EN-1:0]    i_enq_vld = '0;
    logic [EN*IW-1:0] i_enq_imm = '0;
    logic [EN*AW-1:0] o_enq_idx;
    logic [RP*AW-1:0] i_read_idx = '0;
    logic [RP*IW-1:0] o_read_data;
    logic [CP-1:0]    i_clear_vld = '0;
    logic [CP*AW-1:0] i_clear_idx = '0;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [IW-1:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [AW:0] m_head = '0;
    logic [AW:0] m_tail = '0;

    always #5 clk = ~clk;

    imm_buffer #(.SIZE(SIZE), .ENQ_NUM(EN), .READPORT_NUM(RP), .CLEARPORT_NUM(CP), .IMM_W(IW)) dut (
        .clk(clk), .rst(rst), .i_squash_vld(i_squash_vld), .o_can_enq(o_can_enq),
        .i_enq_vld(i_enq_vld), .i_enq_imm(i_enq_imm), .o_enq_idx(o_enq_idx),
        .i_read_idx(i_read_idx), .o_read_data(o_read_data),
        .i_clear_vld(i_clear_vld), .i_clear_idx(i_clear_idx)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        i_squash_vld = 1'b0;
        i_enq_vld    = '0;
        i_clear_vld  = '0;
    endtask

    task automatic apply_reset;
        idle_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        sb.delete();
        m_head = '0;
        m_tail = '0;
    endtask

    task automatic do_enq(input logic [EN-1:0] vld, input logic [EN*IW-1:0] imm);
        logic [EN*AW-1:0] exp_idx;
        logic             acc;
        exp_t             e;
        i_enq_vld = vld;
        i_enq_imm = imm;
        #1;
        for (int k = 0; k < EN; k++) exp_idx[k*AW +: AW] = m_tail[AW-1:0] + AW'(k);
        acc = (m_tail - m_head) <= (AW+1)'(SIZE - EN);
        n_tests++;
        if (o_enq_idx !== exp_idx) begin
            n_fail++;
            $display("FAIL enq_idx: got %h expected %h", o_enq_idx, exp_idx);
        end
        n_tests++;
        if (o_can_enq !== acc) begin
            n_fail++;
            $display("FAIL can_enq: got %b expected %b", o_can_enq, acc);
        end
        if (acc)
            for (int k = 0; k < EN; k++)
                if (vld[k]) begin
                    e.idx  = m_tail[AW-1:0];
                    e.data = imm[k*IW +: IW];
                    sb.push_back(e);
                    m_tail = m_tail + 1'b1;
                end
        tick();
        idle_in();
    endtask

    task automatic rand_enq(input logic [EN-1:0] vld);
        logic [EN*IW-1:0] imm;
        for (int k = 0; k < EN; k++) imm[k*IW +: IW] = IW'($urandom);
        do_enq(vld, imm);
    endtask

    task automatic drain;
        exp_t e [RP];
        int   n;
        while (sb.size() > 0) begin
            n = 0;
            while (n < RP && sb.size() > 0) begin
                e[n] = sb.pop_front();
                i_read_idx[n*AW +: AW] = e[n].idx;
                n++;
            end
            #1;
            for (int p = 0; p < n; p++) begin
                n_tests++;
                if (o_read_data[p*IW +: IW] !== e[p].data) begin
                    n_fail++;
                    $display("FAIL read idx %0d: got %h expected %h", e[p].idx, o_read_data[p*IW +: IW], e[p].data);
                end
            end
        end
    endtask

    task automatic do_clear(input int base, input int n);
        for (int c = 0; c < CP; c++) begin
            i_clear_vld[c] = (c < n);
            i_clear_idx[c*AW +: AW] = AW'((base + c) % SIZE);
        end
        tick();
        idle_in();
    endtask

    task automatic advance(input int n);
        int left  = n;
        int start = int'(m_tail[AW-1:0]);
        while (left > 0) begin
            rand_enq(left >= 4 ? 4'hF : 4'hF >> (4 - left));
            left -= 4;
        end
        drain();
        for (int i = 0; i < n; i += 8) do_clear(start + i, (n - i) > 8 ? 8 : n - i);
        repeat (5) tick();
        m_head = m_tail;
        n_tests++;
        if ({dut.r_head, dut.r_tail} !== {m_head, m_tail}) begin
            n_fail++;
            $display("FAIL advance head/tail: got %h/%h expected %h/%h", dut.r_head, dut.r_tail, m_head, m_tail);
        end
    endtask

    task automatic test_reset;
        apply_reset();
        n_tests++;
        if (o_can_enq !== 1'b1) begin
            n_fail++;
            $display("FAIL reset can_enq: got %b expected 1", o_can_enq);
        end
        n_tests++;
        if (o_enq_idx !== 16'h3210) begin
            n_fail++;
            $display("FAIL reset enq_idx: got %h expected 3210", o_enq_idx);
        end
        n_tests++;
        if ({dut.r_head, dut.r_tail, dut.r_busy} !== 26'h0) begin
            n_fail++;
            $display("FAIL reset state: got %h/%h/%h expected 0/0/0", dut.r_head, dut.r_tail, dut.r_busy);
        end
    endtask

    task automatic test_alloc_read;
        apply_reset();
        do_enq(4'b0111, {20'h0, 20'h33, 20'h22, 20'h11});
        drain();
        n_tests++;
        if ({dut.r_tail, dut.r_busy} !== {5'd3, 16'h0007}) begin
            n_fail++;
            $display("FAIL alloc tail/busy: got %h/%h expected 3/0007", dut.r_tail, dut.r_busy);
        end
    endtask

    task automatic test_full;
        apply_reset();
        repeat (4) rand_enq(4'hF);
        n_tests++;
        if ({o_can_enq, dut.r_head, dut.r_tail} !== {1'b0, 5'd0, 5'd16}) begin
            n_fail++;
            $display("FAIL full state: got %b/%h/%h expected 0/00/10", o_can_enq, dut.r_head, dut.r_tail);
        end
        rand_enq(4'hF);
        n_tests++;
        if (dut.r_tail !== 5'b10000) begin
            n_fail++;
            $display("FAIL full ignored enq tail: got %h expected 10", dut.r_tail);
        end
        drain();
    endtask

    task automatic test_ooo_release;
        apply_reset();
        rand_enq(4'hF);
        rand_enq(4'hF);
        drain();
        for (int c = 0; c < 4; c++) begin
            i_clear_vld[c] = 1'b1;
            i_clear_idx[c*AW +: AW] = (c % 2 == 0) ? 4'd2 : 4'd3;
        end
        tick();
        idle_in();
        repeat (2) tick();
        n_tests++;
        if ({dut.r_head, dut.r_busy} !== {5'd0, 16'h00F3}) begin
            n_fail++;
            $display("FAIL ooo hold: got %h/%h expected 00/00f3", dut.r_head, dut.r_busy);
        end
        do_clear(0, 2);
        n_tests++;
        if (dut.r_head !== 5'd0) begin
            n_fail++;
            $display("FAIL ooo head early: got %h expected 00", dut.r_head);
        end
        tick();
        n_tests++;
        if ({dut.r_head, dut.r_busy} !== {5'd4, 16'h00F0}) begin
            n_fail++;
            $display("FAIL ooo reclaim: got %h/%h expected 04/00f0", dut.r_head, dut.r_busy);
        end
        m_head = 5'd4;
        do_clear(9, 1);
        n_tests++;
        if ({dut.r_head, dut.r_busy} !== {5'd4, 16'h00F0}) begin
            n_fail++;
            $display("FAIL noop clear: got %h/%h expected 04/00f0", dut.r_head, dut.r_busy);
        end
    endtask

    task automatic test_wrap;
        apply_reset();
        advance(16);
        advance(14);
        n_tests++;
        if ({dut.r_head, dut.r_tail} !== {5'd30, 5'd30}) begin
            n_fail++;
            $display("FAIL wrap setup: got %h/%h expected 1e/1e", dut.r_head, dut.r_tail);
        end
        rand_enq(4'hF);
        drain();
        n_tests++;
        if (dut.r_tail !== 5'd2) begin
            n_fail++;
            $display("FAIL wrap tail: got %h expected 02", dut.r_tail);
        end
    endtask

    task automatic test_squash;
        apply_reset();
        rand_enq(4'hF);
        rand_enq(4'hF);
        rand_enq(4'b0011);
        drain();
        i_squash_vld = 1'b1;
        i_enq_vld    = 4'hF;
        i_clear_vld  = '1;
        tick();
        idle_in();
        m_head = m_tail;
        n_tests++;
        if ({o_can_enq, dut.r_head, dut.r_tail, dut.r_busy} !== {1'b1, 5'd10, 5'd10, 16'h0}) begin
            n_fail++;
            $display("FAIL squash: got %b/%h/%h/%h expected 1/0a/0a/0000", o_can_enq, dut.r_head, dut.r_tail, dut.r_busy);
        end
        rand_enq(4'b0001);
        drain();
    endtask

    task automatic test_async_reset;
        apply_reset();
        rand_enq(4'hF);
        rand_enq(4'hF);
        i_enq_vld   = 4'hF;
        i_clear_vld = '1;
        #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({o_can_enq, o_enq_idx, dut.r_head, dut.r_tail, dut.r_busy} !== {1'b1, 16'h3210, 26'h0}) begin
            n_fail++;
            $display("FAIL async reset: got %b/%h/%h/%h/%h expected 1/3210/0/0/0", o_can_enq, o_enq_idx, dut.r_head, dut.r_tail, dut.r_busy);
        end
        tick();
        n_tests++;
        if ({dut.r_head, dut.r_tail, dut.r_busy} !== 26'h0) begin
            n_fail++;
            $display("FAIL reset held: got %h/%h/%h expected 0/0/0", dut.r_head, dut.r_tail, dut.r_busy);
        end
        rst = 1'b0;
        idle_in();
        sb.delete();
        m_head = '0;
        m_tail = '0;
        #1;
        do_enq(4'b0011, {20'h0, 20'h0, 20'hBEEF1, 20'h5A5A5});
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alloc_read();
        test_full();
        test_ooo_release();
        test_wrap();
        test_squash();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
